// File: rtl/i2c_apb_fifo.sv
// i2c_apb_fifo: first-word-fall-through FIFO that sits between the APB bridge
// and the I2C core. One instance is used for TX and one for RX.
// Optional build macro: I2C_FIFO_ERR_EN adds sticky OVERFLOW/UNDERFLOW flags
// and an ERR_CLR input. Without the macro, dropped pushes and ignored pops are
// silent.
module i2c_apb_fifo #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              WR_ENA,
  input  logic [DWIDTH-1:0] WR_DATA,
  input  logic              RD_ENA,
  output logic [DWIDTH-1:0] RD_DATA,
  output logic              FULL,
  output logic              EMPTY,
`ifdef I2C_FIFO_ERR_EN
  input  logic              ERR_CLR,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
`endif
  output logic [AWIDTH:0]   COUNT
);

  localparam int             DEPTH      = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_COUNT = DEPTH[AWIDTH:0];

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign FULL  = (count_q == FULL_COUNT);
  assign EMPTY = (count_q == '0);
  assign COUNT = count_q;

  // A pop needs data; a push needs room, or a simultaneous pop that frees a slot.
  assign do_pop  = RD_ENA && !EMPTY;
  assign do_push = WR_ENA && (!FULL || do_pop);

  // Head word is shown combinationally so the bridge reads it in the same cycle.
  assign RD_DATA = EMPTY ? '0 : mem[rd_ptr];

  // Storage array; deliberately not reset, EMPTY gating keeps stale data hidden.
  always_ff @(posedge PCLK) begin
    if (do_push) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

  // Pointer and occupancy control; pointers wrap naturally at DEPTH.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (AWIDTH+1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (AWIDTH+1)'(1);
      end
    end
  end

`ifdef I2C_FIFO_ERR_EN
  logic drop_push;
  logic drop_pop;

  assign drop_push = WR_ENA && !do_push;
  assign drop_pop  = RD_ENA && EMPTY;

  // Sticky error flags; a new error in the clearing cycle keeps its flag set.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (drop_push) begin
        OVERFLOW <= 1'b1;
      end else if (ERR_CLR) begin
        OVERFLOW <= 1'b0;
      end
      if (drop_pop) begin
        UNDERFLOW <= 1'b1;
      end else if (ERR_CLR) begin
        UNDERFLOW <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2c_apb_fifo.sv
// Self-checking bench for i2c_apb_fifo. Expected read words are queued in a
// scoreboard when pushed and compared when the bench pops them.
// Flag checks are compiled in when I2C_FIFO_ERR_EN is defined.
module tb_i2c_apb_fifo;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        WR_ENA;
  logic [31:0] WR_DATA;
  logic        RD_ENA;
  logic [31:0] RD_DATA;
  logic        FULL;
  logic        EMPTY;
  logic [4:0]  COUNT;
`ifdef I2C_FIFO_ERR_EN
  logic        ERR_CLR;
  logic        OVERFLOW;
  logic        UNDERFLOW;
`endif

  int          checks = 0;
  int          passed = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_word;

  i2c_apb_fifo #(.DWIDTH(32), .AWIDTH(4)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .WR_ENA    (WR_ENA),
    .WR_DATA   (WR_DATA),
    .RD_ENA    (RD_ENA),
    .RD_DATA   (RD_DATA),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
`ifdef I2C_FIFO_ERR_EN
    .ERR_CLR   (ERR_CLR),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW),
`endif
    .COUNT     (COUNT)
  );

  // Free-running 10-unit clock.
  always #5 PCLK = ~PCLK;

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one edge and settle just after it; inputs change only here.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Push one word and record it as the next expected read.
  task automatic push_word(input logic [31:0] d);
    WR_ENA  = 1'b1;
    WR_DATA = d;
    sb.push_back(d);
    tick();
    WR_ENA  = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    WR_ENA = 1'b0;
    RD_ENA = 1'b0;
    WR_DATA = '0;
`ifdef I2C_FIFO_ERR_EN
    ERR_CLR = 1'b0;
`endif
    tick();
    checks++; if (COUNT !== 5'd0) $display("[TB] FAIL reset_count: got %0d want 0", COUNT); else passed++;
    checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) $display("[TB] FAIL reset_flags: got E=%b F=%b want E=1 F=0", EMPTY, FULL); else passed++;
    checks++; if (RD_DATA !== 32'h0) $display("[TB] FAIL reset_rdata: got %h want 00000000", RD_DATA); else passed++;
    PRESET = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      WR_ENA = 1'b1;
      WR_DATA = 32'hC000_0000 + i;
      tick();
    end
    WR_ENA = 1'b0;
    checks++; if (COUNT !== 5'd5) $display("[TB] FAIL pre_reset_count: got %0d want 5", COUNT); else passed++;
    #2;
    PRESET = 1'b1;
    #1;
    checks++; if (COUNT !== 5'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) $display("[TB] FAIL async_reset_state: got C=%0d E=%b F=%b want C=0 E=1 F=0", COUNT, EMPTY, FULL); else passed++;
    checks++; if (RD_DATA !== 32'h0) $display("[TB] FAIL async_reset_rdata: got %h want 00000000", RD_DATA); else passed++;
    #1;
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_order();
    push_word(32'h1111_1111);
    checks++; if (RD_DATA !== 32'h1111_1111 || EMPTY !== 1'b0) $display("[TB] FAIL fwft_first: got %h E=%b want 11111111 E=0", RD_DATA, EMPTY); else passed++;
    push_word(32'h2222_2222);
    push_word(32'h3333_3333);
    for (int i = 0; i < 3; i++) begin
      exp_word = sb.pop_front();
      checks++; if (RD_DATA !== exp_word) $display("[TB] FAIL order_pop%0d: got %h want %h", i, RD_DATA, exp_word); else passed++;
      RD_ENA = 1'b1;
      tick();
      RD_ENA = 1'b0;
    end
    checks++; if (EMPTY !== 1'b1 || COUNT !== 5'd0) $display("[TB] FAIL order_empty: got E=%b C=%0d want E=1 C=0", EMPTY, COUNT); else passed++;
  endtask

  task automatic test_full_drop();
    for (int i = 0; i < 16; i++) push_word(32'h100 + i);
    checks++; if (FULL !== 1'b1 || COUNT !== 5'd16) $display("[TB] FAIL full_flag: got F=%b C=%0d want F=1 C=16", FULL, COUNT); else passed++;
    WR_ENA = 1'b1;
    WR_DATA = 32'hDEAD;
    tick();
    WR_ENA = 1'b0;
    checks++; if (COUNT !== 5'd16 || FULL !== 1'b1) $display("[TB] FAIL drop_count: got C=%0d F=%b want C=16 F=1", COUNT, FULL); else passed++;
    checks++; if (RD_DATA !== 32'h100) $display("[TB] FAIL drop_head: got %h want 00000100", RD_DATA); else passed++;
`ifdef I2C_FIFO_ERR_EN
    checks++; if (OVERFLOW !== 1'b1) $display("[TB] FAIL overflow_set: got %b want 1", OVERFLOW); else passed++;
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    checks++; if (OVERFLOW !== 1'b0) $display("[TB] FAIL overflow_clr: got %b want 0", OVERFLOW); else passed++;
`endif
    for (int i = 0; i < 16; i++) begin
      exp_word = sb.pop_front();
      checks++; if (RD_DATA !== exp_word) $display("[TB] FAIL full_pop%0d: got %h want %h", i, RD_DATA, exp_word); else passed++;
      RD_ENA = 1'b1;
      tick();
      RD_ENA = 1'b0;
    end
    checks++; if (EMPTY !== 1'b1) $display("[TB] FAIL full_drain_empty: got %b want 1", EMPTY); else passed++;
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) push_word(32'h100 + i);
    exp_word = sb.pop_front();
    checks++; if (RD_DATA !== exp_word) $display("[TB] FAIL simul_head: got %h want %h", RD_DATA, exp_word); else passed++;
    WR_ENA = 1'b1;
    WR_DATA = 32'hAAAA;
    RD_ENA = 1'b1;
    sb.push_back(32'hAAAA);
    tick();
    WR_ENA = 1'b0;
    RD_ENA = 1'b0;
    checks++; if (COUNT !== 5'd16 || FULL !== 1'b1) $display("[TB] FAIL simul_count: got C=%0d F=%b want C=16 F=1", COUNT, FULL); else passed++;
    checks++; if (RD_DATA !== 32'h101) $display("[TB] FAIL simul_advance: got %h want 00000101", RD_DATA); else passed++;
    for (int i = 0; i < 16; i++) begin
      exp_word = sb.pop_front();
      checks++; if (RD_DATA !== exp_word) $display("[TB] FAIL simul_pop%0d: got %h want %h", i, RD_DATA, exp_word); else passed++;
      RD_ENA = 1'b1;
      tick();
      RD_ENA = 1'b0;
    end
    checks++; if (exp_word !== 32'hAAAA) $display("[TB] FAIL simul_last: got %h want 0000aaaa", exp_word); else passed++;
    checks++; if (EMPTY !== 1'b1) $display("[TB] FAIL simul_empty: got %b want 1", EMPTY); else passed++;
  endtask

  task automatic test_empty_edges();
    RD_ENA = 1'b1;
    tick();
    RD_ENA = 1'b0;
    checks++; if (COUNT !== 5'd0 || EMPTY !== 1'b1) $display("[TB] FAIL underflow_count: got C=%0d E=%b want C=0 E=1", COUNT, EMPTY); else passed++;
    checks++; if (RD_DATA !== 32'h0) $display("[TB] FAIL underflow_rdata: got %h want 00000000", RD_DATA); else passed++;
`ifdef I2C_FIFO_ERR_EN
    checks++; if (UNDERFLOW !== 1'b1) $display("[TB] FAIL underflow_flag: got %b want 1", UNDERFLOW); else passed++;
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
`endif
    WR_ENA = 1'b1;
    WR_DATA = 32'h5A5A;
    RD_ENA = 1'b1;
    sb.push_back(32'h5A5A);
    tick();
    WR_ENA = 1'b0;
    RD_ENA = 1'b0;
    checks++; if (COUNT !== 5'd1) $display("[TB] FAIL empty_pushpop_count: got %0d want 1", COUNT); else passed++;
    exp_word = sb.pop_front();
    checks++; if (RD_DATA !== exp_word) $display("[TB] FAIL empty_pushpop_data: got %h want %h", RD_DATA, exp_word); else passed++;
    RD_ENA = 1'b1;
    tick();
    RD_ENA = 1'b0;
    checks++; if (EMPTY !== 1'b1) $display("[TB] FAIL empty_pushpop_drain: got %b want 1", EMPTY); else passed++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      push_word(32'(i));
      checks++; if (COUNT !== 5'd1 || FULL !== 1'b0) $display("[TB] FAIL wrap_count%0d: got C=%0d F=%b want C=1 F=0", i, COUNT, FULL); else passed++;
      exp_word = sb.pop_front();
      checks++; if (RD_DATA !== exp_word) $display("[TB] FAIL wrap_pop%0d: got %h want %h", i, RD_DATA, exp_word); else passed++;
      RD_ENA = 1'b1;
      tick();
      RD_ENA = 1'b0;
    end
    checks++; if (EMPTY !== 1'b1 || COUNT !== 5'd0) $display("[TB] FAIL wrap_end: got E=%b C=%0d want E=1 C=0", EMPTY, COUNT); else passed++;
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_order();
    test_full_drop();
    test_simul_full();
    test_empty_edges();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
